uart_rx_fifo: RTL
=================

# uart_rx_fifo

Byte buffer sitting directly downstream of the UART receiver (`UART_rcv`). It accepts each completed byte using the receiver's `rx_rdy`/`rx_rdy_clr` handshake and stores it in a first-word-fall-through FIFO. Core logic drains the FIFO at its own pace. The block decouples the receiver's single-byte holding register from the consumer and flags bytes lost to overflow.

## Interface
- `DEPTH`, default 8: number of byte entries. Must be a power of 2 and ≥ 2. `AW = log2(DEPTH)`.
- `clk` input, 1 bit: system clock, rising-edge active. This is the only clock.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `rx_rdy` input, 1 bit: receiver has a completed byte on `rx_data`.
- `rx_data` input, 8 bits: received byte, stable while `rx_rdy`=1.
- `rx_rdy_clr` output, 1 bit: one-cycle pulse that tells the receiver to drop `rx_rdy`.
- `rd_en` input, 1 bit: consumer pop request.
- `rd_data` output, 8 bits: oldest stored byte (FWFT). Don't-care while `empty`=1.
- `empty` output, 1 bit: count == 0.
- `full` output, 1 bit: count == DEPTH.
- `count` output, AW+1 bits: number of stored bytes, 0..DEPTH.
- `overrun` output, 1 bit: sticky flag, a received byte was dropped.
- `ovr_clr` input, 1 bit: clears `overrun`.

## Operation
- Capture FSM, two states:
  - IDLE: when `rx_rdy`=1, capture the byte, go to ACK, and register `rx_rdy_clr`=1 for the next cycle.
  - ACK: `rx_rdy_clr`=0 except in the first ACK cycle. Stay in ACK while `rx_rdy`=1. Return to IDLE on the first cycle with `rx_rdy`=0. This prevents one byte from being captured twice.
- Capture outcome:
  - If not full, or if full with `rd_en`=1 in the same cycle: write `rx_data` to `mem[wr_ptr]` and advance `wr_ptr`.
  - If full and `rd_en`=0: discard the byte and set `overrun`. `rx_rdy_clr` is still pulsed.
- Pop: `rd_en`=1 with `empty`=0 advances `rd_ptr`. `rd_en` while empty is ignored, with no state change.
- Pointers are AW bits and wrap modulo DEPTH. `count` tracks fill level: +1 on write only, −1 on pop only, unchanged on write+pop.
- Simultaneous push and pop:
  - When empty: the push happens, the pop is ignored, and `count` goes to 1.
  - When full: both happen, `count` stays at DEPTH, and no overrun.
- `overrun`: if set and `ovr_clr` are asserted in the same cycle, set wins.
- `mem` is not reset. Everything else is.

## Timing
- Reset values:
  - state IDLE, `wr_ptr`=`rd_ptr`=0, `count`=0
  - `empty`=1, `full`=0, `overrun`=0, `rx_rdy_clr`=0
- Reset applied mid-operation empties the FIFO immediately. Any partially acknowledged byte is abandoned.
- Capture at edge N (IDLE, `rx_rdy`=1):
  - `rx_rdy_clr`=1 during cycle N+1 only.
  - `count`, `empty` and `full` update after edge N.
  - The byte appears on `rd_data` in cycle N+1 if the FIFO was empty.
- Pop at edge N: the next entry is on `rd_data` after edge N, through a combinational read of `mem[rd_ptr]`.
- Back-to-back bytes: minimum 3 cycles between captures (capture, clr pulse, `rx_rdy` low observed). The UART bit period is far longer than this.
- All outputs except `rd_data` are registered.

## Test plan
- Reset with no traffic → `empty`=1, `full`=0, `count`=0, `overrun`=0, `rx_rdy_clr`=0. Assert `rst` while `count`=3 → `count`=0 and `empty`=1 asynchronously, before the next edge.
- Single byte 0x1D via `rx_rdy` → exactly one `rx_rdy_clr` pulse the cycle after capture, `count`=1, `rd_data`=0x1D. `rd_en` one cycle → `empty`=1.
- `rx_rdy` held high 10 cycles (slow receiver) → one capture, one `rx_rdy_clr` pulse, `count`=1.
- DEPTH=8: push 0x00..0x07 → `full`=1. Push 0x7D → dropped, `overrun`=1, `count`=8. Pop all → 0x00..0x07 in order. `ovr_clr` → `overrun`=0.
- Full FIFO, capture 0xAA with `rd_en`=1 same cycle → `count` stays 8, `overrun`=0. 0xAA emerges last after 7 more pops.
- Wrap-around: 20 push/pop pairs of incrementing data → order preserved across pointer wrap. `rd_en` while empty → no change. `ovr_clr` same cycle as a new overrun → `overrun`=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT byte FIFO behind the UART receiver with rx_rdy/rx_rdy_clr capture and sticky overrun
module uart_rx_fifo #(
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_rdy,
    input  logic [7:0]    rx_data,
    output logic          rx_rdy_clr,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    input  logic          ovr_clr
);

    typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, full_q, overrun_q, clr_q;
    logic          empty_d, full_d, overrun_d, clr_d;
    logic          push, pop, wr, drop;
    logic [7:0]    mem [DEPTH];

    always_comb begin
        push      = (state_q == S_IDLE) && rx_rdy;
        pop       = rd_en && !empty_q;
        // A full FIFO still accepts the byte when a pop frees a slot on the same edge.
        wr        = push && (!full_q || rd_en);
        drop      = push && full_q && !rd_en;

        state_d   = state_q;
        clr_d     = 1'b0;
        case (state_q)
            S_IDLE: if (rx_rdy) begin
                state_d = S_ACK;
                clr_d   = 1'b1;
            end
            S_ACK:  if (!rx_rdy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d  = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d   = count_q;
        case ({wr, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        empty_d   = (count_d == '0);
        full_d    = (count_d == (AW+1)'(DEPTH));

        // Set has priority over clear so a drop coinciding with ovr_clr is never lost.
        overrun_d = drop ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
            clr_q     <= clr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr_q] <= rx_data;
    end

    assign rd_data    = mem[rd_ptr_q];
    assign rx_rdy_clr = clr_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign count      = count_q;
    assign overrun    = overrun_q;

endmodule
